uart_prog_loader: RTL and testbench
===================================

# uart_prog_loader

Parametrised UART program loader that streams framed host data into any of NUM_BANKS on-chip memories (instruction, data, or further banks) over a word-write port, and releases the core when the host closes the session. It sits beside the CPU core on the 10 MHz programming clock and drives the upg-style write bus of the memories. It adds several things the current programming path lacks: explicit base addressing, per-frame checksums with ACK/NAK responses, an inter-byte timeout, and an error counter.

## Interface
- CLKS_PER_BIT, 87: clock cycles per UART bit (10 MHz / 115200).
- DATA_W, 32: memory word width; multiple of 8, ≤ 64.
- NUM_BANKS, 2: number of target memories; ≥ 1.
- BANK_ADDR_W, 14: word-address width per bank; ≤ 16.
- TIMEOUT_CLKS, 1_000_000: idle cycles allowed between bytes inside a frame.

Ports:
- clk  in  1  programming clock; the only clock.
- rst  in  1  reset, synchronous and active-low (0 = reset).
- start  in  1  one-cycle pulse that opens a session; ignored while active=1.
- rx  in  1  UART receive, 8N1, asynchronous.
- tx  out  1  UART transmit, 8N1; idles high.
- wen  out  1  one-cycle write strobe.
- bank  out  max(1,$clog2(NUM_BANKS))  target bank of the current write.
- adr  out  BANK_ADDR_W  word address of the current write.
- dat  out  DATA_W  write data.
- active  out  1  session open; the core is held in reset.
- done  out  1  session closed successfully; held until the next start.
- err_cnt  out  8  count of NAKs sent; saturates at 255.

All outputs reset to 0, except tx, which resets to 1.

## Operation
- Frame format: 0xA5, bank, base_lo, base_hi, len_lo, len_hi, len words (each DATA_W/8 bytes, little-endian), csum.
  - csum is the XOR of every byte from bank through the last payload byte.
  - base and len are 16-bit little-endian.
- States: IDLE, HDR, BANK, BASE0, BASE1, LEN0, LEN1, DATA, CSUM, RESP, DONE.
- IDLE → HDR on start: active=1, done=0.
- HDR: bytes other than 0xA5 are discarded.
- BANK: a value ≥ NUM_BANKS aborts the frame.
- LEN1: base+len > 2^BANK_ADDR_W aborts the frame. len=0 goes straight to CSUM.
- DATA: byte counter assembles words. At each word's last byte, set wen=1 with bank, adr=base+i and dat for one cycle. Writes are not gated by csum; on NAK the written region is undefined and the host resends.
- CSUM: match → send ACK 0x06, otherwise send NAK 0x15 and err_cnt+1.
- Any abort (bad bank, range error, framing error, timeout) sends NAK, increments err_cnt, then returns to HDR.
- RESP: transmit the response byte. Received bytes are dropped until tx completes.
  - After an ACK for len=0 (end-of-session frame): go to DONE, with active=0 and done=1.
  - Otherwise: return to HDR.
- DONE → HDR on start, with done=0 and active=1.
- Framing error (stop bit sampled low) while in BANK..CSUM: abort. In HDR: drop the byte silently.

## Timing
- rx passes through a 2-flop synchroniser.
- Start bit is detected on a synchronised falling edge, then checked low again at CLKS_PER_BIT/2.
- Data bits are sampled at bit centres. The byte is valid for one cycle at the stop-bit centre.
- wen rises the cycle after the byte-valid of a word's final byte.
- tx start bit begins the cycle after the csum byte-valid, or after the abort event. Response lasts 10·CLKS_PER_BIT cycles.
- Timeout counter clears on every byte-valid and counts only in BANK..CSUM. Reaching TIMEOUT_CLKS triggers an abort.
- rst=0 mid-frame: all state and outputs return to reset values immediately; any partial word is lost.
- rst wins over a simultaneous start. start during active=1 is ignored.
- adr never wraps, because the range check precedes DATA.

## Structure
- Package uart_loader_pkg holds:
  - HDR_BYTE 8'hA5, ACK_BYTE 8'h06, NAK_BYTE 8'h15;
  - the state enum type;
  - the bank-width function.
- Sub-module uart_byte_rx contains the synchroniser, sampler and stop-bit check. It outputs byte[7:0], valid and frame_err.
- The TX shifter, FSM, word assembler and timeout counter stay in the top module.

## Test plan
All scenarios use CLKS_PER_BIT=4 and TIMEOUT_CLKS=200.
- Reset, then start, then frame A5 00 10 00 02 00 with words 0x11223344 and 0xAABBCCDD plus correct csum → two wen pulses: bank0/adr 0x10 = 0x11223344 and bank0/adr 0x11 = 0xAABBCCDD; tx sends 0x06; err_cnt=0.
- Same frame with csum XOR 0x01 → same writes, tx 0x15, err_cnt=1, FSM back in HDR.
- Frame with bank=02 → NAK right after the bank byte, no wen, err_cnt+1; a following valid frame is ACKed.
- base=0x3FFF, len=2 → NAK after len_hi, no wen.
- Frame stalls after 3 payload bytes for 250 cycles → NAK, and the 3 bytes produce no wen.
- End frame A5 01 00 00 00 00 01 → ACK, then active=0 and done=1. Pull rst=0 for one cycle mid-frame in a new session → every output returns to its reset value.

Source files
------------

// File: rtl/uart_loader_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | uart_loader_pkg : shared constants, FSM states and width helper           |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
package uart_loader_pkg;

    localparam logic [7:0] HDR_BYTE = 8'hA5;
    localparam logic [7:0] ACK_BYTE = 8'h06;
    localparam logic [7:0] NAK_BYTE = 8'h15;

    typedef enum logic [3:0] {
        IDLE, HDR, BANK, BASE0, BASE1, LEN0, LEN1, DATA, CSUM, RESP, DONE
    } state_t;

    function automatic int bank_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_byte_rx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | uart_byte_rx : 8N1 receiver with 2-flop synchroniser and stop-bit check   |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module uart_byte_rx #(
    parameter int CLKS_PER_BIT = 87
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] rx_byte,
    output logic       valid,
    output logic       frame_err
);
    localparam int c_cnt_w = $clog2(CLKS_PER_BIT + 1);
    localparam logic [c_cnt_w-1:0] c_half = c_cnt_w'(CLKS_PER_BIT / 2 - 1);
    localparam logic [c_cnt_w-1:0] c_full = c_cnt_w'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    rx_state_t          r_state, w_state_next;
    logic               r_sync1, r_sync2, r_sync3;
    logic [c_cnt_w-1:0] r_cnt, w_cnt_next;
    logic [2:0]         r_bit, w_bit_next;
    logic [7:0]         r_shift, w_shift_next;
    logic               r_valid, w_valid;
    logic               r_err, w_err;

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt + 1'b1;
        w_bit_next   = r_bit;
        w_shift_next = r_shift;
        w_valid      = 1'b0;
        w_err        = 1'b0;
        case (r_state)
            RX_IDLE: begin
                w_cnt_next = '0;
                if (r_sync3 && !r_sync2)
                    w_state_next = RX_START;
            end
            RX_START: if (r_cnt == c_half) begin
                // A start bit that is high again at mid-bit was a glitch
                w_cnt_next   = '0;
                w_bit_next   = '0;
                w_state_next = r_sync2 ? RX_IDLE : RX_DATA;
            end
            RX_DATA: if (r_cnt == c_full) begin
                w_cnt_next   = '0;
                w_shift_next = {r_sync2, r_shift[7:1]};
                w_bit_next   = r_bit + 1'b1;
                if (r_bit == 3'd7)
                    w_state_next = RX_STOP;
            end
            RX_STOP: if (r_cnt == c_full) begin
                w_cnt_next   = '0;
                w_valid      = r_sync2;
                w_err        = !r_sync2;
                w_state_next = RX_IDLE;
            end
            default: w_state_next = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= RX_IDLE;
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_sync3 <= 1'b1;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_sync1 <= rx;
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_bit   <= w_bit_next;
            r_shift <= w_shift_next;
            r_valid <= w_valid;
            r_err   <= w_err;
        end
    end

    assign rx_byte   = r_shift;
    assign valid     = r_valid;
    assign frame_err = r_err;

endmodule
`default_nettype wire

// File: rtl/uart_prog_loader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | uart_prog_loader : framed UART loader writing words into on-chip banks    |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module uart_prog_loader
    import uart_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 87,
    parameter int DATA_W       = 32,
    parameter int NUM_BANKS    = 2,
    parameter int BANK_ADDR_W  = 14,
    parameter int TIMEOUT_CLKS = 1_000_000
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic                         rx,
    output logic                         tx,
    output logic                         wen,
    output logic [bank_w(NUM_BANKS)-1:0] bank,
    output logic [BANK_ADDR_W-1:0]       adr,
    output logic [DATA_W-1:0]            dat,
    output logic                         active,
    output logic                         done,
    output logic [7:0]                   err_cnt
);
    localparam int c_bank_w = bank_w(NUM_BANKS);
    localparam int c_bpw    = DATA_W / 8;
    localparam int c_bc_w   = (c_bpw > 1) ? $clog2(c_bpw) : 1;
    localparam int c_tmo_w  = $clog2(TIMEOUT_CLKS + 1);
    localparam int c_tx_w   = $clog2(CLKS_PER_BIT + 1);
    localparam logic [16:0] c_span = 17'd1 << BANK_ADDR_W;

    state_t               r_state, w_state_next;
    logic [7:0]           w_rx_byte;
    logic                 w_rx_valid, w_rx_err;
    logic [c_bank_w-1:0]  r_bank;
    logic [15:0]          r_base, r_rem, w_len_full;
    logic [BANK_ADDR_W-1:0] r_adr_cur;
    logic [c_bc_w-1:0]    r_byte_cnt;
    logic [DATA_W-1:0]    r_word, w_word_next;
    logic [7:0]           r_csum, w_tx_byte;
    logic                 r_len0, r_end;
    logic [c_tmo_w-1:0]   r_tmo;
    logic [8:0]           r_tx_shift;
    logic [c_tx_w-1:0]    r_tx_cnt;
    logic [3:0]           r_tx_bit;
    logic                 r_tx_busy;
    logic w_in_frame, w_tmo_hit, w_tx_go, w_tx_done, w_word_last, w_range_bad, w_bank_bad;

    uart_byte_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .rx_byte   (w_rx_byte),
        .valid     (w_rx_valid),
        .frame_err (w_rx_err)
    );

    generate
        if (DATA_W > 8) begin : g_word_shift
            assign w_word_next = {w_rx_byte, r_word[DATA_W-1:8]};
        end else begin : g_word_byte
            assign w_word_next = w_rx_byte;
        end
    endgenerate

    assign w_in_frame  = r_state inside {BANK, BASE0, BASE1, LEN0, LEN1, DATA, CSUM};
    assign w_tmo_hit   = w_in_frame && !w_rx_valid && (r_tmo == c_tmo_w'(TIMEOUT_CLKS - 1));
    assign w_len_full  = {w_rx_byte, r_rem[7:0]};
    assign w_range_bad = ({1'b0, r_base} + {1'b0, w_len_full}) > c_span;
    assign w_bank_bad  = {24'd0, w_rx_byte} >= 32'(NUM_BANKS);
    assign w_word_last = (r_byte_cnt == c_bc_w'(c_bpw - 1));
    assign w_tx_done   = r_tx_busy && (r_tx_cnt == c_tx_w'(CLKS_PER_BIT - 1)) && (r_tx_bit == 4'd9);

    always_comb begin
        w_state_next = r_state;
        w_tx_go      = 1'b0;
        w_tx_byte    = NAK_BYTE;
        case (r_state)
            IDLE, DONE: if (start) w_state_next = HDR;
            HDR:   if (w_rx_valid && w_rx_byte == HDR_BYTE) w_state_next = BANK;
            BANK:  if (w_rx_valid) begin
                if (w_bank_bad) begin
                    w_state_next = RESP;
                    w_tx_go      = 1'b1;
                end else begin
                    w_state_next = BASE0;
                end
            end
            BASE0: if (w_rx_valid) w_state_next = BASE1;
            BASE1: if (w_rx_valid) w_state_next = LEN0;
            LEN0:  if (w_rx_valid) w_state_next = LEN1;
            LEN1:  if (w_rx_valid) begin
                if (w_range_bad) begin
                    w_state_next = RESP;
                    w_tx_go      = 1'b1;
                end else begin
                    w_state_next = (w_len_full == 16'd0) ? CSUM : DATA;
                end
            end
            DATA:  if (w_rx_valid && w_word_last && r_rem == 16'd1) w_state_next = CSUM;
            CSUM:  if (w_rx_valid) begin
                w_state_next = RESP;
                w_tx_go      = 1'b1;
                w_tx_byte    = (w_rx_byte == r_csum) ? ACK_BYTE : NAK_BYTE;
            end
            RESP:  if (w_tx_done) w_state_next = r_end ? DONE : HDR;
            default: w_state_next = IDLE;
        endcase
        if (w_in_frame && (w_rx_err || w_tmo_hit)) begin
            w_state_next = RESP;
            w_tx_go      = 1'b1;
            w_tx_byte    = NAK_BYTE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_state_next;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            tx <= 1'b1;  wen <= 1'b0;  bank <= '0;  adr <= '0;  dat <= '0;
            active <= 1'b0;  done <= 1'b0;  err_cnt <= '0;
            r_bank <= '0;  r_base <= '0;  r_rem <= '0;  r_adr_cur <= '0;
            r_byte_cnt <= '0;  r_word <= '0;  r_csum <= '0;  r_len0 <= 1'b0;
            r_end <= 1'b0;  r_tmo <= '0;  r_tx_shift <= '0;  r_tx_cnt <= '0;
            r_tx_bit <= '0;  r_tx_busy <= 1'b0;
        end else begin
            wen   <= 1'b0;
            r_tmo <= (w_in_frame && !w_rx_valid) ? r_tmo + 1'b1 : '0;
            if ((r_state == IDLE || r_state == DONE) && start) begin
                active <= 1'b1;
                done   <= 1'b0;
            end
            if (r_state == RESP && w_tx_done && r_end) begin
                active <= 1'b0;
                done   <= 1'b1;
            end
            case (r_state)
                HDR:   r_csum <= '0;
                BANK:  if (w_rx_valid) begin
                    r_bank <= w_rx_byte[c_bank_w-1:0];
                    r_csum <= r_csum ^ w_rx_byte;
                end
                BASE0: if (w_rx_valid) begin
                    r_base[7:0] <= w_rx_byte;
                    r_csum      <= r_csum ^ w_rx_byte;
                end
                BASE1: if (w_rx_valid) begin
                    r_base[15:8] <= w_rx_byte;
                    r_csum       <= r_csum ^ w_rx_byte;
                end
                LEN0:  if (w_rx_valid) begin
                    r_rem[7:0] <= w_rx_byte;
                    r_csum     <= r_csum ^ w_rx_byte;
                end
                LEN1:  if (w_rx_valid) begin
                    r_rem      <= w_len_full;
                    r_len0     <= (w_len_full == 16'd0);
                    r_adr_cur  <= r_base[BANK_ADDR_W-1:0];
                    r_byte_cnt <= '0;
                    r_csum     <= r_csum ^ w_rx_byte;
                end
                DATA:  if (w_rx_valid) begin
                    r_csum <= r_csum ^ w_rx_byte;
                    r_word <= w_word_next;
                    if (w_word_last) begin
                        wen        <= 1'b1;
                        bank       <= r_bank;
                        adr        <= r_adr_cur;
                        dat        <= w_word_next;
                        r_adr_cur  <= r_adr_cur + 1'b1;
                        r_rem      <= r_rem - 1'b1;
                        r_byte_cnt <= '0;
                    end else begin
                        r_byte_cnt <= r_byte_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
            // Only an ACKed zero-length frame closes the session
            if (w_tx_go) begin
                r_end      <= r_len0 && (w_tx_byte == ACK_BYTE);
                tx         <= 1'b0;
                r_tx_shift <= {1'b1, w_tx_byte};
                r_tx_cnt   <= '0;
                r_tx_bit   <= '0;
                r_tx_busy  <= 1'b1;
                if (w_tx_byte == NAK_BYTE && err_cnt != 8'hFF)
                    err_cnt <= err_cnt + 1'b1;
            end else if (r_tx_busy) begin
                if (r_tx_cnt == c_tx_w'(CLKS_PER_BIT - 1)) begin
                    r_tx_cnt <= '0;
                    if (r_tx_bit == 4'd9) begin
                        r_tx_busy <= 1'b0;
                    end else begin
                        tx         <= r_tx_shift[0];
                        r_tx_shift <= {1'b1, r_tx_shift[8:1]};
                        r_tx_bit   <= r_tx_bit + 1'b1;
                    end
                end else begin
                    r_tx_cnt <= r_tx_cnt + 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_prog_loader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_uart_prog_loader : randomized frames checked against a frame model     |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module tb_uart_prog_loader;
    import uart_loader_pkg::*;

    localparam int CPB = 4;
    localparam int TMO = 200;
    localparam int AW  = 14;
    localparam int NB  = 2;

    typedef logic [7:0]  bq_t[$];
    typedef logic [31:0] wq_t[$];

    logic clk = 1'b0, rst = 1'b0, start = 1'b0, rx = 1'b1;
    logic tx, wen, active, done;
    logic [bank_w(NB)-1:0] bank;
    logic [AW-1:0] adr;
    logic [31:0] dat;
    logic [7:0] err_cnt;

    uart_prog_loader #(
        .CLKS_PER_BIT(CPB), .DATA_W(32), .NUM_BANKS(NB),
        .BANK_ADDR_W(AW), .TIMEOUT_CLKS(TMO)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .rx(rx), .tx(tx), .wen(wen),
        .bank(bank), .adr(adr), .dat(dat), .active(active), .done(done),
        .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    int n_tests = 0, n_fail = 0, m_err = 0;
    logic [55:0] wr_q[$];
    logic [7:0]  tx_q[$];

    always @(negedge clk) if (rst && wen) wr_q.push_back({8'(bank), 16'(adr), dat});

    initial begin : tx_decoder
        logic [7:0] b;
        forever begin
            @(negedge clk);
            if (rst && tx == 1'b0) begin
                repeat (2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clk);
                    b[i] = tx;
                end
                repeat (CPB) @(negedge clk);
                tx_q.push_back(b);
            end
        end
    end

    initial begin : watchdog
        #3_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic uart_send(input logic [7:0] b);
        logic [9:0] fr;
        fr = {1'b1, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rx = fr[i];
            repeat (CPB) @(negedge clk);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    function automatic bq_t make_frame(input logic [7:0] bk, input logic [15:0] base,
                                       input wq_t w, input bit bad);
        bq_t f;
        logic [7:0] cs;
        f = '{8'hA5, bk, base[7:0], base[15:8], 8'(w.size()), 8'(w.size() >> 8)};
        foreach (w[i]) for (int k = 0; k < 4; k++) f.push_back(w[i][8*k +: 8]);
        cs = 8'h00;
        for (int i = 1; i < f.size(); i++) cs ^= f[i];
        f.push_back(bad ? (cs ^ 8'h01) : cs);
        return f;
    endfunction

    // Reference: decide from the frame contents alone what the loader must do
    task automatic run_frame(input string tag, input bq_t f, input int n_lim);
        logic [55:0] exp_wr[$];
        logic [7:0] exp_resp, got, cs;
        int bk, base, len, n_send, n_words;
        bit ok, end_sess;
        bk = f[1];
        base = {f[3], f[2]};
        len = {f[5], f[4]};
        n_send = (n_lim < f.size()) ? n_lim : f.size();
        end_sess = 1'b0;
        exp_resp = NAK_BYTE;
        if (bk >= NB) begin
            if (n_send > 2) n_send = 2;
        end else if (base + len > (1 << AW)) begin
            if (n_send > 6) n_send = 6;
        end else begin
            n_words = (n_send > 6) ? (n_send - 6) / 4 : 0;
            if (n_words > len) n_words = len;
            for (int w = 0; w < n_words; w++)
                exp_wr.push_back({8'(bk), 16'(base + w),
                                  f[6+4*w+3], f[6+4*w+2], f[6+4*w+1], f[6+4*w]});
            if (n_send == f.size()) begin
                cs = 8'h00;
                for (int i = 1; i < f.size() - 1; i++) cs ^= f[i];
                exp_resp = (cs == f[f.size()-1]) ? ACK_BYTE : NAK_BYTE;
                end_sess = (exp_resp == ACK_BYTE) && (len == 0);
            end
        end
        if (exp_resp == NAK_BYTE && m_err < 255) m_err++;

        wr_q.delete();
        tx_q.delete();
        for (int i = 0; i < n_send; i++) uart_send(f[i]);
        ok = 1'b0;
        got = 8'h00;
        for (int i = 0; i < 3000 && !ok; i++) begin
            @(negedge clk);
            if (tx_q.size() > 0) begin
                got = tx_q.pop_front();
                ok = 1'b1;
            end
        end
        chk({tag, "/resp_seen"}, ok, 1);
        chk({tag, "/resp"}, got, exp_resp);
        repeat (10) @(negedge clk);
        chk({tag, "/n_wr"}, wr_q.size(), exp_wr.size());
        foreach (exp_wr[i])
            chk({tag, "/wr"}, (i < wr_q.size()) ? wr_q[i] : 56'hX, exp_wr[i]);
        chk({tag, "/err_cnt"}, err_cnt, m_err);
        chk({tag, "/active"}, active, !end_sess);
        chk({tag, "/done"}, done, end_sess);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "/tx"}, tx, 1);
        chk({tag, "/wen"}, wen, 0);
        chk({tag, "/bank"}, bank, 0);
        chk({tag, "/adr"}, adr, 0);
        chk({tag, "/dat"}, dat, 0);
        chk({tag, "/active"}, active, 0);
        chk({tag, "/done"}, done, 0);
        chk({tag, "/err_cnt"}, err_cnt, 0);
    endtask

    initial begin : stim
        wq_t w, none;
        bq_t f;
        int len;
        repeat (5) @(negedge clk);
        chk_reset_outputs("reset");
        rst = 1'b1;
        @(negedge clk);
        pulse_start();
        chk("start/active", active, 1);

        w = '{32'h11223344, 32'hAABBCCDD};
        run_frame("good2", make_frame(8'h00, 16'h0010, w, 1'b0), 1000);
        run_frame("badcsum", make_frame(8'h00, 16'h0010, w, 1'b1), 1000);
        run_frame("badbank", make_frame(8'h02, 16'h0000, w, 1'b0), 1000);
        w = '{$urandom(), $urandom()};
        run_frame("after_bad", make_frame(8'h01, 16'h0100, w, 1'b0), 1000);
        run_frame("range", make_frame(8'h00, 16'h3FFF, w, 1'b0), 1000);
        run_frame("stall", make_frame(8'h00, 16'h0020, w, 1'b0), 9);

        for (int it = 0; it < 8; it++) begin
            w.delete();
            len = $urandom_range(1, 3);
            for (int k = 0; k < len; k++) w.push_back($urandom());
            f = make_frame(8'($urandom_range(0, 2)), 16'($urandom_range(0, 16383)), w,
                           $urandom_range(0, 3) == 0);
            run_frame("rand", f, 1000);
        end

        run_frame("end", make_frame(8'h01, 16'h0000, none, 1'b0), 1000);

        pulse_start();
        chk("restart/active", active, 1);
        chk("restart/done", done, 0);
        uart_send(8'hA5);
        uart_send(8'h00);
        uart_send(8'h30);
        @(negedge clk) rst = 1'b0;
        @(negedge clk);
        chk_reset_outputs("midreset");
        rst = 1'b1;
        m_err = 0;
        pulse_start();
        w = '{$urandom()};
        run_frame("post_reset", make_frame(8'h00, 16'h0040, w, 1'b0), 1000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
